// File: rtl/comp_arith_pkg.sv
// Shared definitions for the complex arithmetic datapath (comp_mul / comp_div).
// Width helpers are functions so each instance derives its sizes from its own W/FRAC.
package comp_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // numerator width: holds a_r*b_r + a_i*b_i including the -2^(W-1) corner
    function automatic int nw_of(input int w);
        return 2 * w + 1;
    endfunction

    // denominator / remainder width
    function automatic int dw_of(input int w);
        return 2 * w;
    endfunction

    // restoring-division iteration count
    function automatic int n_of(input int w, input int frac);
        return 2 * w + frac;
    endfunction

    // signed quotient width
    function automatic int qw_of(input int w, input int frac);
        return 2 * w + 1 + frac;
    endfunction

endpackage

// File: rtl/udiv_step.sv
// One restoring-division iteration: shift the next dividend bit into the remainder,
// subtract the divisor when it fits, and shift the resulting quotient bit in.
module udiv_step
    import comp_arith_pkg::*;
#(
    parameter int DW = dw_of(8),
    parameter int N  = n_of(8, 0)
) (
    input  logic [DW-1:0] den,
    input  logic [DW-1:0] rem_in,
    input  logic [N-1:0]  dq_in,
    output logic [DW-1:0] rem_out,
    output logic [N-1:0]  dq_out
);

    logic [DW:0] trial;
    logic [DW:0] diff;
    logic        fits;

    // dq holds the unconsumed dividend bits at the top and the quotient bits at the bottom
    always_comb begin
        trial   = {rem_in, dq_in[N-1]};
        diff    = trial - {1'b0, den};
        fits    = (trial >= {1'b0, den});
        rem_out = fits ? diff[DW-1:0] : trial[DW-1:0];
        dq_out  = {dq_in[N-2:0], fits};
    end

endmodule

// File: rtl/comp_div.sv
// Iterative complex divider q = a / b: one cycle to form numerators and denominator,
// 2W+FRAC restoring-division steps shared by real and imaginary parts, one cycle to sign.
//
// state | meaning
// IDLE  | waiting for i_en, busy low
// MUL   | numerators, signs and denominator registered
// DIV   | one quotient bit per cycle for both parts
// DONE  | signs applied, result strobed
module comp_div
    import comp_arith_pkg::*;
#(
    parameter int W    = 8,
    parameter int FRAC = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [W-1:0]           a_r,
    input  logic signed [W-1:0]           a_i,
    input  logic signed [W-1:0]           b_r,
    input  logic signed [W-1:0]           b_i,
    input  logic                          i_en,
    output logic                          busy,
    output logic                          o_valid,
    output logic                          div_zero,
    output logic signed [2*W+FRAC:0]      q_r,
    output logic signed [2*W+FRAC:0]      q_i
);

    localparam int NW = nw_of(W);
    localparam int DW = dw_of(W);
    localparam int N  = n_of(W, FRAC);
    localparam int QW = qw_of(W, FRAC);
    localparam int CW = $clog2(N);

    state_t state, state_nxt;

    logic signed [W-1:0] op_ar, op_ai, op_br, op_bi;
    logic [DW-1:0]       den;
    logic [DW-1:0]       rem_r, rem_i, rem_r_nxt, rem_i_nxt;
    logic [N-1:0]        dq_r, dq_i, dq_r_nxt, dq_i_nxt;
    logic                neg_r, neg_i, dz;
    logic [CW-1:0]       cnt;

    logic signed [NW-1:0] ar_x, ai_x, br_x, bi_x;
    logic signed [NW-1:0] num_r_c, num_i_c, den_c;
    logic [NW-1:0]        mag_r_c, mag_i_c;
    logic [DW-1:0]        den_w;
    logic [N-1:0]         dvd_r_c, dvd_i_c;
    logic [QW-1:0]        res_r, res_i;

    // operands are sign-extended to the numerator width before multiplying
    always_comb begin
        ar_x    = NW'(op_ar);
        ai_x    = NW'(op_ai);
        br_x    = NW'(op_br);
        bi_x    = NW'(op_bi);
        num_r_c = ar_x * br_x + ai_x * bi_x;
        num_i_c = ai_x * br_x - ar_x * bi_x;
        den_c   = br_x * br_x + bi_x * bi_x;
        den_w   = den_c[DW-1:0];
        mag_r_c = num_r_c[NW-1] ? -num_r_c : num_r_c;
        mag_i_c = num_i_c[NW-1] ? -num_i_c : num_i_c;
        dvd_r_c = N'(mag_r_c[DW-1:0]) << FRAC;
        dvd_i_c = N'(mag_i_c[DW-1:0]) << FRAC;
        res_r   = neg_r ? -{1'b0, dq_r} : {1'b0, dq_r};
        res_i   = neg_i ? -{1'b0, dq_i} : {1'b0, dq_i};
    end

    udiv_step #(.DW(DW), .N(N)) u_step_r (
        .den     (den),
        .rem_in  (rem_r),
        .dq_in   (dq_r),
        .rem_out (rem_r_nxt),
        .dq_out  (dq_r_nxt)
    );

    udiv_step #(.DW(DW), .N(N)) u_step_i (
        .den     (den),
        .rem_in  (rem_i),
        .dq_in   (dq_i),
        .rem_out (rem_i_nxt),
        .dq_out  (dq_i_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_en) state_nxt = MUL;
            MUL:     state_nxt = (den_w == '0) ? DONE : DIV;
            DIV:     if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_ar    <= '0;
            op_ai    <= '0;
            op_br    <= '0;
            op_bi    <= '0;
            den      <= '0;
            rem_r    <= '0;
            rem_i    <= '0;
            dq_r     <= '0;
            dq_i     <= '0;
            neg_r    <= 1'b0;
            neg_i    <= 1'b0;
            dz       <= 1'b0;
            cnt      <= '0;
            o_valid  <= 1'b0;
            div_zero <= 1'b0;
            q_r      <= '0;
            q_i      <= '0;
        end else begin
            o_valid  <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_en) begin
                        op_ar <= a_r;
                        op_ai <= a_i;
                        op_br <= b_r;
                        op_bi <= b_i;
                    end
                end
                MUL: begin
                    den   <= den_w;
                    neg_r <= num_r_c[NW-1];
                    neg_i <= num_i_c[NW-1];
                    dq_r  <= dvd_r_c;
                    dq_i  <= dvd_i_c;
                    rem_r <= '0;
                    rem_i <= '0;
                    dz    <= (den_w == '0);
                    cnt   <= CW'(N - 1);
                end
                DIV: begin
                    rem_r <= rem_r_nxt;
                    rem_i <= rem_i_nxt;
                    dq_r  <= dq_r_nxt;
                    dq_i  <= dq_i_nxt;
                    cnt   <= cnt - CW'(1);
                end
                DONE: begin
                    // on divide-by-zero dq still holds the dividend, so force zero
                    o_valid  <= 1'b1;
                    div_zero <= dz;
                    q_r      <= dz ? '0 : res_r;
                    q_i      <= dz ? '0 : res_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comp_div.sv
// Scoreboard bench for comp_div: expected quotients from an integer model are queued
// at stimulus time and popped when o_valid fires (W=8 with FRAC=0 and FRAC=4).
module tb_comp_div;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [7:0]  a_r, a_i, b_r, b_i;
    logic               en0, en4;
    logic               busy0, ov0, dz0;
    logic signed [16:0] q0_r, q0_i;
    logic               busy4, ov4, dz4;
    logic signed [20:0] q4_r, q4_i;

    int errors = 0;
    int checks = 0;

    typedef struct {
        longint r;
        longint i;
        bit     dz;
    } exp_t;

    exp_t sb0[$];
    exp_t sb4[$];

    always #5 clk = ~clk;

    comp_div #(.W(8), .FRAC(0)) dut0 (
        .clk(clk), .rst(rst), .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
        .i_en(en0), .busy(busy0), .o_valid(ov0), .div_zero(dz0), .q_r(q0_r), .q_i(q0_i)
    );

    comp_div #(.W(8), .FRAC(4)) dut4 (
        .clk(clk), .rst(rst), .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
        .i_en(en4), .busy(busy4), .o_valid(ov4), .div_zero(dz4), .q_r(q4_r), .q_i(q4_i)
    );

    function automatic exp_t model(input int ar, input int ai, input int br, input int bi, input int frac);
        exp_t   e;
        longint nr, ni, den;
        nr  = longint'(ar) * br + longint'(ai) * bi;
        ni  = longint'(ai) * br - longint'(ar) * bi;
        den = longint'(br) * br + longint'(bi) * bi;
        if (den == 0) begin
            e.r = 0; e.i = 0; e.dz = 1'b1;
        end else begin
            e.r = (nr * (longint'(1) << frac)) / den;
            e.i = (ni * (longint'(1) << frac)) / den;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    function automatic longint got_r(input bit sel);
        return sel ? longint'(q4_r) : longint'(q0_r);
    endfunction

    function automatic longint got_i(input bit sel);
        return sel ? longint'(q4_i) : longint'(q0_i);
    endfunction

    // drives one request for one edge; returns at #1 after that edge
    task automatic start_op(input bit sel, input int ar, input int ai, input int br, input int bi, input bit push);
        a_r = 8'(ar); a_i = 8'(ai); b_r = 8'(br); b_i = 8'(bi);
        if (push) begin
            if (sel) sb4.push_back(model(ar, ai, br, bi, 4));
            else     sb0.push_back(model(ar, ai, br, bi, 0));
        end
        if (sel) en4 = 1'b1; else en0 = 1'b1;
        @(posedge clk); #1;
        en0 = 1'b0; en4 = 1'b0;
    endtask

    // counts edges until o_valid (bounded) and busy-high samples from the accept edge on
    task automatic wait_valid(input bit sel, output int lat, output int busy_n);
        lat = 0; busy_n = 0;
        while (lat < 60) begin
            if (sel ? busy4 : busy0) busy_n++;
            @(posedge clk); #1;
            lat++;
            if (sel ? ov4 : ov0) break;
        end
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (ov0) n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en0 = 1'b0; en4 = 1'b0;
        a_r = '0; a_i = '0; b_r = '0; b_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b want 0", ov0); end
        checks++; if (dz0 !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b want 0", dz0); end
        checks++; if (q0_r !== 17'sd0 || q0_i !== 17'sd0) begin errors++; $display("FAIL reset_q: got (%0d,%0d) want (0,0)", q0_r, q0_i); end
        checks++; if (busy4 !== 1'b0 || ov4 !== 1'b0 || q4_r !== 21'sd0) begin errors++; $display("FAIL reset_frac4: busy=%b o_valid=%b q_r=%0d want 0", busy4, ov4, q4_r); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int   lat, bn;
        exp_t e;
        start_op(0, 100, 50, 1, 0, 1);
        wait_valid(0, lat, bn);
        e = sb0.pop_front();
        checks++; if (lat != 18) begin errors++; $display("FAIL basic_latency: got %0d want 18", lat); end
        checks++; if (bn != 18) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 18", bn); end
        checks++; if (got_r(0) != e.r || got_i(0) != e.i) begin errors++; $display("FAIL basic_q: got (%0d,%0d) want (%0d,%0d)", q0_r, q0_i, e.r, e.i); end
        checks++; if (dz0 !== e.dz) begin errors++; $display("FAIL basic_div_zero: got %b want %b", dz0, e.dz); end
        @(posedge clk); #1;
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: o_valid got %b want 0", ov0); end
        checks++; if (got_r(0) != e.r || got_i(0) != e.i) begin errors++; $display("FAIL basic_hold: got (%0d,%0d) want (%0d,%0d)", q0_r, q0_i, e.r, e.i); end
    endtask

    task automatic test_vectors();
        int   vec [10][4] = '{
            '{-100, 50, 0, 1}, '{-7, 0, 2, 0}, '{7, 0, 2, 0},
            '{-128, -128, -128, -128}, '{-128, -128, -128, 0}, '{127, -128, -128, 127},
            '{0, 0, 3, -4}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        int   lat, bn;
        exp_t e;
        for (int k = 7; k < 10; k++) begin
            for (int j = 0; j < 4; j++) vec[k][j] = int'($urandom_range(255)) - 128;
            if (vec[k][2] == 0 && vec[k][3] == 0) vec[k][2] = 1;
        end
        for (int k = 0; k < 10; k++) begin
            start_op(0, vec[k][0], vec[k][1], vec[k][2], vec[k][3], 1);
            wait_valid(0, lat, bn);
            e = sb0.pop_front();
            checks++; if (lat != 18) begin errors++; $display("FAIL vec%0d_latency: got %0d want 18", k, lat); end
            checks++; if (got_r(0) != e.r || got_i(0) != e.i || dz0 !== e.dz) begin
                errors++; $display("FAIL vec%0d_q: got (%0d,%0d,dz=%b) want (%0d,%0d,dz=%b)", k, q0_r, q0_i, dz0, e.r, e.i, e.dz);
            end
        end
    endtask

    task automatic test_div_zero();
        int   lat, bn;
        exp_t e;
        start_op(0, 5, 5, 0, 0, 1);
        wait_valid(0, lat, bn);
        e = sb0.pop_front();
        checks++; if (lat != 2) begin errors++; $display("FAIL dz_latency: got %0d want 2", lat); end
        checks++; if (dz0 !== 1'b1 || e.dz != 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", dz0); end
        checks++; if (q0_r !== 17'sd0 || q0_i !== 17'sd0) begin errors++; $display("FAIL dz_q: got (%0d,%0d) want (0,0)", q0_r, q0_i); end
        @(posedge clk); #1;
        checks++; if (dz0 !== 1'b0) begin errors++; $display("FAIL dz_pulse_width: got %b want 0", dz0); end
        start_op(0, 7, 0, 2, 0, 1);
        wait_valid(0, lat, bn);
        e = sb0.pop_front();
        checks++; if (dz0 !== 1'b0 || got_r(0) != e.r || got_i(0) != e.i) begin
            errors++; $display("FAIL dz_followup: got (%0d,%0d,dz=%b) want (%0d,%0d,dz=0)", q0_r, q0_i, dz0, e.r, e.i);
        end
    endtask

    task automatic test_ignore_busy();
        int   lat, bn, extra;
        exp_t e;
        start_op(0, 20, -10, 3, 1, 1);
        repeat (5) @(posedge clk);
        #1;
        start_op(0, 1, 1, 1, 0, 0);
        wait_valid(0, lat, bn);
        e = sb0.pop_front();
        checks++; if (lat != 12) begin errors++; $display("FAIL busy_drop_latency: got %0d want 12", lat); end
        checks++; if (got_r(0) != e.r || got_i(0) != e.i) begin errors++; $display("FAIL busy_drop_q: got (%0d,%0d) want (%0d,%0d)", q0_r, q0_i, e.r, e.i); end
        count_valid(30, extra);
        checks++; if (extra != 0) begin errors++; $display("FAIL busy_drop_extra_valid: got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int   lat, bn;
        exp_t e;
        start_op(0, -90, 33, 5, -7, 1);
        wait_valid(0, lat, bn);
        e = sb0.pop_front();
        checks++; if (got_r(0) != e.r || got_i(0) != e.i) begin errors++; $display("FAIL b2b_first_q: got (%0d,%0d) want (%0d,%0d)", q0_r, q0_i, e.r, e.i); end
        start_op(0, 60, -120, -9, 4, 1);
        wait_valid(0, lat, bn);
        e = sb0.pop_front();
        checks++; if (lat != 18) begin errors++; $display("FAIL b2b_latency: got %0d want 18", lat); end
        checks++; if (got_r(0) != e.r || got_i(0) != e.i) begin errors++; $display("FAIL b2b_second_q: got (%0d,%0d) want (%0d,%0d)", q0_r, q0_i, e.r, e.i); end
    endtask

    task automatic test_reset_mid();
        int n;
        start_op(0, 100, 100, 3, 3, 0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy0 !== 1'b0 || ov0 !== 1'b0 || dz0 !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: busy=%b o_valid=%b div_zero=%b want 0", busy0, ov0, dz0); end
        checks++; if (q0_r !== 17'sd0 || q0_i !== 17'sd0) begin errors++; $display("FAIL midrst_q: got (%0d,%0d) want (0,0)", q0_r, q0_i); end
        count_valid(30, n);
        checks++; if (n != 0) begin errors++; $display("FAIL midrst_no_valid: got %0d want 0", n); end
    endtask

    task automatic test_frac4();
        int   lat, bn;
        exp_t e;
        start_op(1, 7, 0, 2, 0, 1);
        wait_valid(1, lat, bn);
        e = sb4.pop_front();
        checks++; if (lat != 22) begin errors++; $display("FAIL frac4_latency: got %0d want 22", lat); end
        checks++; if (got_r(1) != e.r || got_i(1) != e.i) begin errors++; $display("FAIL frac4_q: got (%0d,%0d) want (%0d,%0d)", q4_r, q4_i, e.r, e.i); end
        start_op(1, -7, 3, 2, 1, 1);
        wait_valid(1, lat, bn);
        e = sb4.pop_front();
        checks++; if (got_r(1) != e.r || got_i(1) != e.i || dz4 !== 1'b0) begin
            errors++; $display("FAIL frac4_neg_q: got (%0d,%0d,dz=%b) want (%0d,%0d,dz=0)", q4_r, q4_i, dz4, e.r, e.i);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_div_zero();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_frac4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/comp_div.md
Name: comp_div

Overview:
- Iterative complex divider, the inverse companion of the comp_mul complex multiplier.
- Computes q = a / b for two's-complement complex operands using a multi-cycle restoring division, with a single-cycle accept and a one-cycle result pulse.
- Sits beside comp_mul in the arithmetic datapath and uses the same operand naming and the same 2W+1 numerator width as comp_mul's outputs.

Parameters:
- W, 8, operand component width (signed).
- FRAC, 0, fractional bits in the quotient (fixed-point Q.FRAC).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_r  in  W  dividend real part, signed.
- a_i  in  W  dividend imaginary part, signed.
- b_r  in  W  divisor real part, signed.
- b_i  in  W  divisor imaginary part, signed.
- i_en  in  1  start request; sampled only when busy=0.
- busy  out  1  high while an operation is in flight.
- o_valid  out  1  one-cycle result strobe.
- div_zero  out  1  qualifies o_valid: divisor was 0+0i.
- q_r  out  QW=2W+1+FRAC  quotient real part, signed.
- q_i  out  QW  quotient imaginary part, signed.

Behaviour:
- Reset: rst is synchronous and active-high with one clock. Forces state IDLE and sets busy, o_valid, div_zero, q_r and q_i to 0. Reset mid-operation aborts the operation; no o_valid is produced for it.
- Math:
  - num_r = a_r*b_r + a_i*b_i; num_i = a_i*b_r - a_r*b_i, both signed 2W+1 bits.
  - den = b_r^2 + b_i^2, unsigned 2W bits; maximum 2^(2W-1).
  - q_x = trunc(num_x * 2^FRAC / den), truncated toward zero. Magnitudes are divided; the sign is num_x's sign, and a zero quotient is always +0.
- FSM: IDLE -> MUL -> DIV (N = 2W+FRAC cycles) -> DONE -> IDLE.
  - IDLE: i_en=1 at edge k latches the operands and moves to MUL. busy=0 only in IDLE.
  - MUL (edge k+1): registers num_r/num_i magnitudes and signs, plus den. If den==0, go to DONE; otherwise go to DIV with the iteration counter set to N-1.
  - DIV: per edge, shift one dividend bit into each remainder. Subtract den if remainder >= den and set the quotient bit. Both real and imag share den and advance in lockstep. Leave DIV when the counter reaches 0.
  - DONE: on the next edge, apply signs, register q_r/q_i, pulse o_valid=1, and return to IDLE.
- Latency:
  - Normal case: accept at edge k gives o_valid high in the cycle after edge k+N+2 (18 clocks for W=8, FRAC=0). busy is high from after edge k through edge k+N+2.
  - Divide by zero: o_valid comes after edge k+2 with div_zero=1 and q_r=q_i=0.
- Handshake:
  - i_en while busy=1 is ignored; the request is dropped with no queuing and no error.
  - i_en in the same cycle that o_valid is high is accepted, because the state is IDLE, allowing back-to-back operations.
- Outputs hold their values between strobes. o_valid and div_zero are high for exactly one cycle per accepted operation.
- Boundary: with all components = -2^(W-1), num_r = 2^(2W-1) must be represented without overflow, which the 2W+1 bit width guarantees. No saturation is ever needed.

Decomposition:
- Shared package comp_arith_pkg holds:
  - the state enum {IDLE, MUL, DIV, DONE};
  - width helper localparams: NW=2W+1, DW=2W, N=2W+FRAC, QW=2W+1+FRAC.
- Sub-module udiv_step: one restoring-division iteration (remainder and quotient bits in, remainder and quotient bits out, den in). Instantiated twice (real and imag).
- Control FSM, counter and sign handling stay in comp_div.

Test Plan:
- W=8, FRAC=0: a=(100,50), b=(1,0) -> q=(100,50), div_zero=0, o_valid exactly 18 cycles after accept, busy high for 18 cycles.
- a=(-100,50), b=(0,1) -> q=(50,100). a=(-7,0), b=(2,0) -> q=(-3,0) (truncate toward zero). a=(7,0), b=(2,0) -> q=(3,0).
- a=(-128,-128), b=(-128,-128) -> q=(1,0); a=(-128,-128), b=(-128,0) -> q=(1,1). Width extremes must not overflow.
- b=(0,0), a=(5,5) -> o_valid 2 cycles after accept, div_zero=1, q=(0,0). The next operation then returns div_zero=0.
- Pulse i_en during busy -> ignored, exactly one o_valid. Assert i_en in the o_valid cycle -> second result follows after 18 more cycles. Assert rst mid-DIV -> no o_valid, all outputs 0.
- FRAC=4 instance: a=(7,0), b=(2,0) -> q_r=56 (3.5), q_i=0, latency 22 cycles.
